// File: rtl/etapa_busqueda_pkg.sv
// pkg_procesador: definitions shared by the fetch stage, decode and the
// load-use hazard unit.
//   ADDR_W_DEF / INSTR_W_DEF : default word-address and instruction widths
//   NOP_INSTR                : bubble instruction loaded into F/D
//   estado_busqueda_t        : fetch FSM state, encoded as {inflight, skid_valid}
package pkg_procesador;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  // Bit 1 = a memory read is in flight, bit 0 = skid buffer holds data.
  // 2'b11 is never legal.
  typedef enum logic [1:0] {
    VACIO    = 2'b00,
    FLUJO    = 2'b10,
    RETENIDO = 2'b01
  } estado_busqueda_t;

endpackage

// File: rtl/etapa_busqueda_if.sv
// etapa_busqueda_if: synchronous instruction-memory port.
//   addr : word address (driven by fetch)
//   rd   : read strobe (driven by fetch)
//   data : read data, valid the cycle after rd=1 (driven by memory)
// Modports: master = fetch stage, slave = instruction memory.
interface etapa_busqueda_if
  import pkg_procesador::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic [ADDR_W-1:0]  addr;
  logic               rd;
  logic [INSTR_W-1:0] data;

  modport master (output addr, output rd, input data);
  modport slave  (input addr, input rd, output data);

endinterface

// File: rtl/etapa_busqueda_buffer_retencion.sv
// buffer_retencion: one-entry skid register holding an instruction and its PC.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : discard contents (branch squash)
//   capture         : load d_instr/d_pc and mark valid
//   drain           : mark empty after the contents were consumed
//   valid, q_instr, q_pc : stored entry
module buffer_retencion #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               capture,
  input  logic               drain,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] q_instr,
  output logic [ADDR_W-1:0]  q_pc
);

  // Payload needs no reset: it is only read while valid is set.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid   <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/etapa_busqueda.sv
// etapa_busqueda: instruction-fetch stage. Owns the PC, drives the
// synchronous instruction memory and loads the F/D pipeline register.
//   clk, rst   : clock, synchronous active-high reset
//   stall      : hold PC and F/D (load-use hold from the hazard unit)
//   salto      : branch taken in Exe; salto_dir is the target
//   imem       : instruction-memory port (addr/rd combinational)
//   instr_F, pc_F, valido_F : F/D register (valido_F=0 marks a bubble)
// Priority: rst > salto > stall > normal fetch.
module etapa_busqueda
  import pkg_procesador::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               salto,
  input  logic [ADDR_W-1:0]  salto_dir,
  etapa_busqueda_if.master   imem,
  output logic [INSTR_W-1:0] instr_F,
  output logic [ADDR_W-1:0]  pc_F,
  output logic               valido_F
);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  inflight_pc;
  estado_busqueda_t   estado_q;
  logic               inflight;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;
  logic               skid_capture;
  logic               skid_drain;
  logic               skid_clear;

  assign inflight = (estado_q == FLUJO);

  always_comb begin
    imem.addr    = salto ? salto_dir : pc_q;
    imem.rd      = !rst && (salto || !stall);
    skid_clear   = salto;
    // Only the first stall cycle after a read can capture; afterwards the
    // state is RETENIDO and nothing is in flight.
    skid_capture = !salto && stall && inflight;
    skid_drain   = !salto && !stall && skid_valid;
  end

  buffer_retencion #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear   (skid_clear),
    .capture (skid_capture),
    .drain   (skid_drain),
    .d_instr (imem.data),
    .d_pc    (inflight_pc),
    .valid   (skid_valid),
    .q_instr (skid_instr),
    .q_pc    (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight_pc <= RESET_PC;
      estado_q    <= VACIO;
      instr_F     <= INSTR_W'(NOP_INSTR);
      pc_F        <= '0;
      valido_F    <= 1'b0;
    end else if (salto) begin
      pc_q        <= salto_dir + ADDR_W'(1);
      inflight_pc <= salto_dir;
      estado_q    <= FLUJO;
      instr_F     <= INSTR_W'(NOP_INSTR);
      valido_F    <= 1'b0;
    end else if (stall) begin
      if (estado_q == FLUJO) estado_q <= RETENIDO;
    end else begin
      pc_q        <= pc_q + ADDR_W'(1);
      inflight_pc <= pc_q;
      estado_q    <= FLUJO;
      case (estado_q)
        RETENIDO: begin
          instr_F  <= skid_instr;
          pc_F     <= skid_pc;
          valido_F <= 1'b1;
        end
        FLUJO: begin
          instr_F  <= imem.data;
          pc_F     <= inflight_pc;
          valido_F <= 1'b1;
        end
        default: begin
          instr_F  <= INSTR_W'(NOP_INSTR);
          valido_F <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A read in flight together with a full skid buffer means a fetched word
  // would be lost.
  a_no_flujo_y_skid : assert property (@(posedge clk) disable iff (rst)
    !(inflight && skid_valid));
  a_skid_coherente : assert property (@(posedge clk) disable iff (rst)
    skid_valid == (estado_q == RETENIDO));
`endif

endmodule

// File: tb/tb_etapa_busqueda.sv
module tb_etapa_busqueda;
  import pkg_procesador::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        salto = 1'b0;
  logic [15:0] salto_dir = '0;

  logic [31:0] instr0, instr1;
  logic [15:0] pc0, pc1;
  logic        v0, v1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        ev;
    logic [15:0] epc;
    logic        c1;
    logic        ev1;
    logic [15:0] epc1;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  etapa_busqueda_if #(.ADDR_W(16), .INSTR_W(32)) imem0 ();
  etapa_busqueda_if #(.ADDR_W(16), .INSTR_W(32)) imem1 ();

  etapa_busqueda #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .salto(salto), .salto_dir(salto_dir),
    .imem(imem0.master), .instr_F(instr0), .pc_F(pc0), .valido_F(v0)
  );

  etapa_busqueda #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .salto(salto), .salto_dir(salto_dir),
    .imem(imem1.master), .instr_F(instr1), .pc_F(pc1), .valido_F(v1)
  );

  // Synchronous instruction memories: word k holds 0x1000_0000 + k.
  always @(posedge clk) begin
    if (imem0.rd) imem0.data <= 32'h1000_0000 + {16'h0000, imem0.addr};
    if (imem1.rd) imem1.data <= 32'h1000_0000 + {16'h0000, imem1.addr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic fd_check(input string tag, input logic v, input logic [15:0] pc,
                          input logic [31:0] instr, input logic ev, input logic [15:0] epc);
    cmp({tag, " valido_F"}, {31'h0, v}, {31'h0, ev});
    if (ev) begin
      cmp({tag, " pc_F"}, {16'h0, pc}, {16'h0, epc});
      cmp({tag, " instr_F"}, instr, 32'h1000_0000 + {16'h0000, epc});
    end else begin
      cmp({tag, " instr_F nop"}, instr, 32'h0);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational memory port,
  // then compare F/D after the edge against the queued expectation.
  task automatic ciclo(input logic r, input logic st, input logic sa, input logic [15:0] dir,
                       input logic erd, input logic ev, input logic [15:0] epc,
                       input logic c1, input logic ev1, input logic [15:0] epc1,
                       input string tag);
    exp_t e;
    rst = r; stall = st; salto = sa; salto_dir = dir;
    e.ev = ev; e.epc = epc; e.c1 = c1; e.ev1 = ev1; e.epc1 = epc1; e.tag = tag;
    sb.push_back(e);
    #1;
    if (!r) cmp({tag, " imem_rd"}, {31'h0, imem0.rd}, {31'h0, erd});
    if (sa) cmp({tag, " imem_addr"}, {16'h0, imem0.addr}, {16'h0, dir});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    fd_check({e.tag, " dut0"}, v0, pc0, instr0, e.ev, e.epc);
    if (e.c1) fd_check({e.tag, " dut1"}, v1, pc1, instr1, e.ev1, e.epc1);
  endtask

  initial begin
    // Reset
    ciclo(1, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 16'h0, "reset");
    cmp("reset pc_F dut0", {16'h0, pc0}, 32'h0);
    cmp("reset pc_F dut1", {16'h0, pc1}, 32'h0);

    // Free run from RESET_PC (dut1 wraps from 0xFFFF)
    ciclo(0, 0, 0, 16'h0, 1, 0, 16'h0000, 1, 0, 16'h0000, "c0");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0000, 1, 1, 16'hFFFF, "c1");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0001, 1, 1, 16'h0000, "c2");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0002, 1, 1, 16'h0001, "c3");
    for (int k = 3; k <= 4; k++)
      ciclo(0, 0, 0, 16'h0, 1, 1, 16'(k), 0, 0, 16'h0, "run");

    // Three-cycle stall while F/D holds pc 4, then no-bubble release
    for (int i = 0; i < 3; i++)
      ciclo(0, 1, 0, 16'h0, 0, 1, 16'h0004, 0, 0, 16'h0, "stall");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0005, 0, 0, 16'h0, "release");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0006, 0, 0, 16'h0, "release+1");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0007, 0, 0, 16'h0, "release+2");

    // Branch while F/D holds pc 7
    ciclo(0, 0, 1, 16'h0040, 1, 0, 16'h0, 0, 0, 16'h0, "salto");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0040, 0, 0, 16'h0, "salto+1");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0041, 0, 0, 16'h0, "salto+2");

    // Branch together with stall while the skid is full: branch wins
    ciclo(0, 1, 0, 16'h0, 0, 1, 16'h0041, 0, 0, 16'h0, "pre-stall");
    ciclo(0, 1, 1, 16'h0040, 1, 0, 16'h0, 0, 0, 16'h0, "salto+stall");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0040, 0, 0, 16'h0, "salto+stall+1");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0041, 0, 0, 16'h0, "salto+stall+2");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0042, 0, 0, 16'h0, "salto+stall+3");

    // Reset in the second cycle of a stall
    ciclo(0, 1, 0, 16'h0, 0, 1, 16'h0042, 0, 0, 16'h0, "stall1");
    ciclo(1, 1, 0, 16'h0, 0, 0, 16'h0, 1, 0, 16'h0, "rst-in-stall");
    cmp("rst-in-stall pc_F dut0", {16'h0, pc0}, 32'h0);
    cmp("rst-in-stall pc_F dut1", {16'h0, pc1}, 32'h0);
    ciclo(0, 0, 0, 16'h0, 1, 0, 16'h0, 1, 0, 16'h0, "restart0");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0000, 1, 1, 16'hFFFF, "restart1");
    ciclo(0, 0, 0, 16'h0, 1, 1, 16'h0001, 1, 1, 16'h0000, "restart2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/etapa_busqueda.md
# etapa_busqueda

Instruction-fetch stage of the filter processor pipeline: owns the PC, drives the synchronous instruction memory and loads the fetch/decode (F/D) pipeline register consumed by decode and the load-use hazard unit. It is directly upstream of the hazard unit and also consumes that unit's hold requests. Branch redirects resolved in Exe squash the F/D register. A one-entry skid buffer preserves the in-flight memory read across stalls, so a released stall costs no bubble.

## Interface
- ADDR_W, 16, PC / instruction-memory word-address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  load-use hold from the hazard unit (its PC_EN/F_Reg_EN request); 1 = hold PC and F/D
- salto  in  1  branch/jump taken, resolved in Exe
- salto_dir  in  ADDR_W  branch target, valid when salto=1
- imem_addr  out  ADDR_W  instruction-memory address (combinational)
- imem_rd  out  1  memory read strobe (combinational)
- imem_data  in  INSTR_W  read data, valid the cycle after imem_rd=1
- instr_F  out  INSTR_W  F/D instruction
- pc_F  out  ADDR_W  F/D instruction address
- valido_F  out  1  F/D holds a real instruction (0 = bubble)

## Operation
- State: pc_q (next fetch address), inflight + inflight_pc, skid_valid/skid_instr/skid_pc, F/D register.
- FSM over (inflight, skid_valid): VACIO (0,0), FLUJO (1,0), RETENIDO (0,1). The state (1,1) is unreachable and must be flagged by an assertion.
- Priority is rst > salto > stall > normal.
- rst: pc_q=RESET_PC, inflight=0, skid_valid=0, instr_F=NOP_INSTR, pc_F=0, valido_F=0. State becomes VACIO.
- salto:
  - imem_addr=salto_dir, imem_rd=1, pc_q<=salto_dir+1, inflight<=1, inflight_pc<=salto_dir.
  - F/D<=NOP_INSTR with valido_F<=0. The skid buffer and any in-flight data are discarded.
  - salto overrides a simultaneous stall.
- stall (no salto):
  - imem_rd=0, imem_addr=pc_q, pc_q and F/D hold.
  - If inflight: skid<=(imem_data, inflight_pc), skid_valid<=1, inflight<=0 (FLUJO->RETENIDO). Otherwise state is unchanged.
  - A multi-cycle stall captures only once.
- normal:
  - imem_addr=pc_q, imem_rd=1, pc_q<=pc_q+1, inflight<=1, inflight_pc<=pc_q.
  - F/D source, in priority order:
    - skid (skid_valid<=0, valido_F<=1)
    - otherwise in-flight data (instr_F<=imem_data, pc_F<=inflight_pc, valido_F<=1)
    - otherwise NOP_INSTR with valido_F<=0 and pc_F unchanged.
- PC arithmetic is modulo 2^ADDR_W: 2^ADDR_W−1 wraps to 0 with no flag.
- The block never samples imem_data in a cycle following imem_rd=0.

## Timing
- Fetch latency: address issued in cycle t appears in F/D at the end of cycle t+1.
- After reset deasserts (cycle 0): instruction at RESET_PC is in F/D after cycle 1, with valido_F=1.
- Branch penalty: one bubble. The salto cycle loads a NOP; the target instruction is in F/D one cycle later.
- Stall of N cycles: F/D is frozen for N cycles. On the release cycle the F/D register loads the skid instruction; throughput then resumes with no extra bubble.
- Reset asserted mid-stall or mid-branch clears everything within the same edge.
- All outputs are registered except imem_addr and imem_rd.

## Structure
- Shared package pkg_procesador holds:
  - NOP_INSTR constant (all zeros)
  - fetch-state enum {VACIO, FLUJO, RETENIDO}
  - ADDR_W and INSTR_W defaults, shared with decode and the hazard unit
- Sub-module buffer_retencion is a one-entry skid register (capture, drain, clear) carrying instr+pc. The top level contains the PC, the F/D register and the control FSM.

## Test plan
- Reset then free-run, RESET_PC=0, memory word k = 0x1000_0000+k:
  - valido_F=0 after cycle 0.
  - instr_F=0x1000_0000 / pc_F=0 after cycle 1.
  - Increments by one per cycle thereafter.
- stall=1 for 3 cycles while F/D holds pc 4:
  - F/D stays at pc 4 and imem_rd=0 throughout.
  - Release yields pc 5 and then pc 6 on consecutive cycles with no bubble.
- salto=1, salto_dir=0x0040 while F/D holds pc 7: next F/D is a NOP (valido_F=0), then pc 0x0040, then 0x0041.
- salto and stall asserted together: the branch wins, the skid is discarded, and the sequence matches the previous scenario.
- RESET_PC=0xFFFF: pc_F sequence is 0xFFFF, 0x0000, 0x0001.
- rst asserted during the second cycle of a stall: all outputs return to their reset values next edge, and fetch restarts at RESET_PC.
